// File: rtl/max7219_spi_tx_pkg.sv
// Shared MAX7219 definitions: register addresses, frame width and the
// transmit FSM state encoding.
package max7219_pkg;

    localparam int unsigned FRAME_BITS = 16;

    localparam logic [7:0] NOOP         = 8'h00;
    localparam logic [7:0] DIGIT0       = 8'h01;
    localparam logic [7:0] DIGIT1       = 8'h02;
    localparam logic [7:0] DIGIT2       = 8'h03;
    localparam logic [7:0] DIGIT3       = 8'h04;
    localparam logic [7:0] DIGIT4       = 8'h05;
    localparam logic [7:0] DIGIT5       = 8'h06;
    localparam logic [7:0] DIGIT6       = 8'h07;
    localparam logic [7:0] DIGIT7       = 8'h08;
    localparam logic [7:0] DECODE_MODE  = 8'h09;
    localparam logic [7:0] INTENSITY    = 8'h0A;
    localparam logic [7:0] SCAN_LIMIT   = 8'h0B;
    localparam logic [7:0] SHUTDOWN     = 8'h0C;
    localparam logic [7:0] DISPLAY_TEST = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCK_LO,
        ST_SCK_HI,
        ST_HOLD,
        ST_GAP
    } tx_state_t;

endpackage

// File: rtl/max7219_spi_tx_if.sv
// Register-write request and serial pin bundle between the display
// controller (master) and the transmit engine (slave).
interface max7219_spi_tx_if;
    import max7219_pkg::*;

    logic       start;
    logic [7:0] addr_in;
    logic [7:0] din;
    logic       sck;
    logic       dout;
    logic       cs;
    logic       busy;
    logic       done;

    modport master (
        output start, addr_in, din,
        input  sck, dout, cs, busy, done
    );

    modport slave (
        input  start, addr_in, din,
        output sck, dout, cs, busy, done
    );

endinterface

// File: rtl/max7219_tick_gen.sv
// Phase timer: pulses phase_end once every CLK_DIV cycles while enabled;
// the count restarts from zero whenever enable drops.
module max7219_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic phase_end
);
    import max7219_pkg::*;

    localparam int unsigned     CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (!enable || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    assign phase_end = enable && (cnt == LAST);

endmodule

// File: rtl/max7219_spi_tx.sv
// MAX7219 serial transmitter: shifts one 16-bit {addr,data} frame MSB-first
// on sck/dout framed by cs, then holds cs high for one phase to latch it.
module max7219_spi_tx
    import max7219_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    max7219_spi_tx_if.slave  bus
);

    tx_state_t             state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    // bit[4] is the terminal flag, set once all 16 bits have gone out
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic                  sck_q, sck_d;
    logic                  dout_q, dout_d;
    logic                  cs_q, cs_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tick_en;
    logic                  phase_end;

    assign tick_en = (state_q != ST_IDLE);

    max7219_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clock     (clock),
        .reset     (reset),
        .enable    (tick_en),
        .phase_end (phase_end)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            sck_q     <= 1'b0;
            dout_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sck_q     <= sck_d;
            dout_q    <= dout_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Outputs are computed one cycle ahead so every pin comes from a flop.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sck_d     = sck_q;
        dout_d    = dout_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cs_d   = 1'b1;
                sck_d  = 1'b0;
                dout_d = 1'b0;
                busy_d = 1'b0;
                if (bus.start) begin
                    shift_d   = {bus.addr_in, bus.din};
                    bit_cnt_d = '0;
                    state_d   = ST_SCK_LO;
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    dout_d    = bus.addr_in[7];
                end
            end
            ST_SCK_LO: begin
                if (phase_end) begin
                    state_d = ST_SCK_HI;
                    sck_d   = 1'b1;
                end
            end
            ST_SCK_HI: begin
                if (phase_end) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    sck_d     = 1'b0;
                    if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                        state_d = ST_HOLD;
                        dout_d  = 1'b0;
                    end else begin
                        state_d = ST_SCK_LO;
                        dout_d  = shift_q[FRAME_BITS-2];
                    end
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    state_d = ST_GAP;
                    cs_d    = 1'b1;
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.sck  = sck_q;
    assign bus.dout = dout_q;
    assign bus.cs   = cs_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_max7219_spi_tx.sv
// Bench for max7219_spi_tx: four instances (CLK_DIV 1..4) checked every cycle
// against a time-since-acceptance waveform model, plus directed frame checks.
module tb_max7219_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [4];
    logic       start_v [4];
    logic [7:0] addr_v  [4];
    logic [7:0] din_v   [4];
    logic       sck_o [4], dout_o [4], cs_o [4], busy_o [4], done_o [4];

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    for (genvar gi = 0; gi < 4; gi++) begin : u
        max7219_spi_tx_if bus ();
        assign bus.start   = start_v[gi];
        assign bus.addr_in = addr_v[gi];
        assign bus.din     = din_v[gi];
        assign sck_o[gi]   = bus.sck;
        assign dout_o[gi]  = bus.dout;
        assign cs_o[gi]    = bus.cs;
        assign busy_o[gi]  = bus.busy;
        assign done_o[gi]  = bus.done;

        max7219_spi_tx #(
            .CLK_DIV (gi + 1)
        ) dut (
            .clock (clk),
            .reset (rst_v[gi]),
            .bus   (bus)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] out_vec(input int n);
        return {cs_o[n], sck_o[n], dout_o[n], busy_o[n], done_o[n]};
    endfunction

    // Model: t = cycles since acceptance (0 = idle); frame fixed at acceptance.
    int          t_m  [4] = '{default: 0};
    logic [15:0] fr_m [4];

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (!rst_v[n])
                t_m[n] = 0;
            else if ((t_m[n] == 0 || t_m[n] == 34 * (n + 1) + 1) && start_v[n]) begin
                fr_m[n] = {addr_v[n], din_v[n]};
                t_m[n]  = 1;
            end else if (t_m[n] == 34 * (n + 1) + 1)
                t_m[n] = 0;
            else if (t_m[n] > 0)
                t_m[n]++;
        end
    end

    function automatic logic [4:0] exp_out(input int t, input int h, input logic [15:0] f);
        logic cs, sck, dout, busy, done;
        cs   = !(t >= 1 && t <= 33 * h);
        busy = (t >= 1 && t <= 34 * h);
        done = (t == 34 * h + 1);
        sck  = 1'b0;
        dout = 1'b0;
        if (t >= 1 && t <= 32 * h) begin
            sck  = ((t - 1) % (2 * h)) >= h;
            dout = f[15 - (t - 1) / (2 * h)];
        end
        return {cs, sck, dout, busy, done};
    endfunction

    always @(negedge clk) begin
        if (cmp_en)
            for (int n = 0; n < 4; n++)
                check($sformatf("model_u%0d_t%0d", n, t_m[n]), 32'(out_vec(n)),
                      32'(exp_out(t_m[n], n + 1, fr_m[n])));
    end

    // Frame capture: dout sampled on each sck rise, word logged on cs rise.
    logic        ps [4] = '{default: 1'b0};
    logic        pc [4] = '{default: 1'b1};
    logic [15:0] sh [4] = '{default: 16'h0};
    logic [15:0] words [4][8];
    int          nframes [4] = '{default: 0};

    always @(negedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (sck_o[n] && !ps[n]) sh[n] = {sh[n][14:0], dout_o[n]};
            if (cs_o[n] && !pc[n]) begin
                words[n][nframes[n] % 8] = sh[n];
                nframes[n]++;
            end
            ps[n] = sck_o[n];
            pc[n] = cs_o[n];
        end
    end

    task automatic wait_done(input int n, input int lim, output int k);
        k = -1;
        for (int i = 1; i <= lim; i++) begin
            if (done_o[n]) begin
                k = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input int n, input logic [7:0] a, input logic [7:0] d,
                             input int len, input int exp_busy, input int exp_cs,
                             input int exp_dcyc, input logic [15:0] exp_word, input string nm);
        int nb = 0, nc = 0, nd = 0, dcyc = -1, n0;
        n0 = nframes[n];
        start_v[n] = 1'b1; addr_v[n] = a; din_v[n] = d;
        @(negedge clk);
        start_v[n] = 1'b0;
        for (int k = 1; k <= len; k++) begin
            if (busy_o[n]) nb++;
            if (!cs_o[n]) nc++;
            if (done_o[n]) begin nd++; dcyc = k; end
            @(negedge clk);
        end
        check({nm, "_busy_cycles"}, nb, exp_busy);
        check({nm, "_cs_low_cycles"}, nc, exp_cs);
        check({nm, "_done_count"}, nd, 1);
        check({nm, "_done_cycle"}, dcyc, exp_dcyc);
        check({nm, "_frames"}, nframes[n] - n0, 1);
        check({nm, "_word"}, 32'(words[n][n0 % 8]), 32'(exp_word));
    endtask

    logic sck_r [0:105], dout_r [0:105], cs_r [0:105];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, dk, nd, nb, d1, bad, nrise, last_rise, last_fall, cs_fall, cs_rise, unstable;
        for (int n = 0; n < 4; n++) begin
            rst_v[n] = 1'b0; start_v[n] = 1'b0; addr_v[n] = '0; din_v[n] = '0;
        end
        repeat (3) @(negedge clk);
        for (int n = 0; n < 4; n++)
            check($sformatf("reset_state_u%0d", n), 32'(out_vec(n)), 32'h10);
        for (int n = 0; n < 4; n++) rst_v[n] = 1'b1;
        cmp_en = 1'b1;

        // Idle: nothing moves for 100 cycles without a start.
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            for (int n = 0; n < 4; n++) if (out_vec(n) !== 5'b10000) bad++;
        end
        check("idle_100_cycles", bad, 0);

        // H=2, SHUTDOWN=1 with a one-cycle start pulse.
        run_frame(1, 8'h0C, 8'h01, 72, 68, 66, 69, 16'h0C01, "t1");

        // H=1, back-to-back frames with start in the done cycle.
        n0 = nframes[0];
        start_v[0] = 1'b1; addr_v[0] = 8'h0A; din_v[0] = 8'h05;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 60, dk);
        check("t2_done1_cycle", dk, 35);
        start_v[0] = 1'b1; addr_v[0] = 8'h0B; din_v[0] = 8'h07;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("t2_b2b_busy", 32'(busy_o[0]), 1);
        wait_done(0, 60, dk);
        check("t2_done2_cycle", dk, 35);
        repeat (3) @(negedge clk);
        check("t2_frames", nframes[0] - n0, 2);
        check("t2_word1", 32'(words[0][n0 % 8]), 32'h0A05);
        check("t2_word2", 32'(words[0][(n0 + 1) % 8]), 32'h0B07);

        // H=4, start held high while addr/din change every cycle.
        n0 = nframes[3]; nd = 0; d1 = -1;
        for (int i = 0; i <= 150; i++) begin
            if (done_o[3]) begin nd++; d1 = i; end
            start_v[3] = 1'b1; addr_v[3] = 8'(i); din_v[3] = 8'(255 - i);
            @(negedge clk);
        end
        start_v[3] = 1'b0;
        check("t3_done1_count", nd, 1);
        check("t3_done1_cycle", d1, 137);
        wait_done(3, 200, dk);
        check("t3_done2_cycle", dk, 124);
        repeat (3) @(negedge clk);
        check("t3_frames", nframes[3] - n0, 2);
        check("t3_word1", 32'(words[3][n0 % 8]), 32'h00FF);
        check("t3_word2", 32'(words[3][(n0 + 1) % 8]), 32'h8976);

        // H=3, frame FF00: phase lengths, dout stability, cs hold after last fall.
        n0 = nframes[2];
        start_v[2] = 1'b1; addr_v[2] = 8'hFF; din_v[2] = 8'h00;
        sck_r[0] = sck_o[2]; dout_r[0] = dout_o[2]; cs_r[0] = cs_o[2];
        for (int k = 1; k <= 105; k++) begin
            @(negedge clk);
            start_v[2] = 1'b0;
            sck_r[k] = sck_o[2]; dout_r[k] = dout_o[2]; cs_r[k] = cs_o[2];
        end
        bad = 0; nrise = 0; unstable = 0;
        last_rise = -1; last_fall = -1; cs_fall = -1; cs_rise = -1;
        for (int k = 1; k <= 105; k++) begin
            if (!cs_r[k] && cs_r[k-1]) cs_fall = k;
            if (cs_r[k] && !cs_r[k-1]) cs_rise = k;
            if (sck_r[k] && !sck_r[k-1]) begin
                nrise++;
                if (k - ((last_fall < 0) ? cs_fall : last_fall) != 3) bad++;
                last_rise = k;
            end
            if (!sck_r[k] && sck_r[k-1]) begin
                if (k - last_rise != 3) bad++;
                last_fall = k;
            end
            if (sck_r[k] && sck_r[k-1] && dout_r[k] !== dout_r[k-1]) unstable++;
        end
        check("t4_sck_rises", nrise, 16);
        check("t4_phase_len_errors", bad, 0);
        check("t4_dout_unstable_hi", unstable, 0);
        check("t4_cs_fall_cycle", cs_fall, 1);
        check("t4_cs_rise_after_last_fall", cs_rise - last_fall, 3);
        check("t4_word", 32'(words[2][n0 % 8]), 32'hFF00);

        // H=2, asynchronous reset mid-frame, then a clean frame.
        start_v[1] = 1'b1; addr_v[1] = 8'h55; din_v[1] = 8'hAA;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (19) @(negedge clk);
        check("t5_busy_before_reset", 32'(busy_o[1]), 1);
        #1 rst_v[1] = 1'b0;
        #1 check("t5_reset_immediate", 32'(out_vec(1)), 32'h10);
        @(negedge clk);
        @(negedge clk);
        rst_v[1] = 1'b1;
        nd = 0; nb = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_o[1]) nd++;
            if (busy_o[1]) nb++;
        end
        check("t5_no_done_after_abort", nd, 0);
        check("t5_no_busy_after_abort", nb, 0);
        run_frame(1, 8'h12, 8'h34, 72, 68, 66, 69, 16'h1234, "t5");

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
